wb_cmd_parser: RTL

Upstream stage of the Wishbone command master. It converts a stream of 8-bit ASCII bytes from the UART receiver into 34-bit command words: `{2-bit sub-code, 32-bit payload}`. It holds each word on a strobe/busy handshake until the master accepts it. It also back-pressures the byte source while a finished word waits.

---
 rtl/wb_cmd_parser.sv | 115 +++++++++++
 1 files changed

// File: rtl/wb_cmd_parser.sv
// ASCII byte stream to 34-bit Wishbone command words {sub-code, payload}.
// One finished word is held on a strobe/busy handshake; the byte source is stalled while it waits.
module wb_cmd_parser (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_stb,
  input  logic [7:0]  i_byte,
  output logic        o_busy,
  output logic        o_cmd_stb,
  output logic [33:0] o_cmd_word,
  input  logic        i_cmd_busy,
  output logic        o_err
);

  typedef enum logic [0:0] {StIdle, StAccum} state_e;

  state_e      state_q;
  logic [1:0]  sub_q;
  logic [31:0] acc_q;
  logic [3:0]  cnt_q;
  logic        cmd_stb_q;
  logic [33:0] cmd_word_q;
  logic        err_q;

  logic       accept;
  logic       is_hex;
  logic       is_cmd;
  logic       is_bad;
  logic [3:0] nibble;
  logic [1:0] code;

  assign o_busy     = cmd_stb_q && i_cmd_busy;
  assign o_cmd_stb  = cmd_stb_q;
  assign o_cmd_word = cmd_word_q;
  assign o_err      = err_q;
  assign accept     = i_stb && !o_busy;
  assign is_bad     = i_byte[7];

  always_comb begin
    is_hex = 1'b0;
    nibble = 4'd0;
    if (i_byte >= "0" && i_byte <= "9") begin
      is_hex = 1'b1;
      nibble = i_byte[3:0];
    end else if ((i_byte >= "A" && i_byte <= "F") || (i_byte >= "a" && i_byte <= "f")) begin
      // Low nibble of 'A'..'F' / 'a'..'f' is 1..6
      is_hex = 1'b1;
      nibble = i_byte[3:0] + 4'd9;
    end
  end

  always_comb begin
    is_cmd = 1'b1;
    code   = 2'b00;
    case (i_byte)
      "R", "r": code = 2'b00;
      "W", "w": code = 2'b01;
      "A", "a": code = 2'b10;
      "S", "s": code = 2'b11;
      default:  is_cmd = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= StIdle;
      sub_q      <= 2'b00;
      acc_q      <= 32'd0;
      cnt_q      <= 4'd0;
      cmd_stb_q  <= 1'b0;
      cmd_word_q <= 34'd0;
      err_q      <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (cmd_stb_q && !i_cmd_busy) cmd_stb_q <= 1'b0;
      if (accept) begin
        unique case (state_q)
          StIdle: begin
            if (is_bad) begin
              err_q <= 1'b1;
            end else if (is_cmd) begin
              sub_q   <= code;
              acc_q   <= 32'd0;
              cnt_q   <= 4'd0;
              state_q <= StAccum;
            end
          end
          StAccum: begin
            // HEX is tested before CMD so 'a'/'A' count as digits here
            if (is_bad) begin
              err_q   <= 1'b1;
              state_q <= StIdle;
            end else if (is_hex) begin
              acc_q <= {acc_q[27:0], nibble};
              if (cnt_q != 4'd9) cnt_q <= cnt_q + 4'd1;
              if (cnt_q == 4'd8) err_q <= 1'b1;
            end else begin
              cmd_word_q <= {sub_q, acc_q};
              cmd_stb_q  <= 1'b1;
              if (is_cmd) begin
                sub_q <= code;
                acc_q <= 32'd0;
                cnt_q <= 4'd0;
              end else begin
                state_q <= StIdle;
              end
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule
